fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_axis_hold.sv | 26 ++
 rtl/fpu_issue_ctrl.sv | 103 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared unit codes, state encoding and operator codes for the FPU issue controller
package fpu_pkg;
  localparam int NUM_UNITS = 7;
  typedef enum logic [2:0] {U_ADDSUB, U_MUL, U_DIV, U_COMP, U_CVTSW, U_CVTWS, U_SQRT} unit_e;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t RECV = 2'd2;
  localparam state_t DONE = 2'd3;
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_EQ  = 8'h14;
  localparam logic [7:0] OP_LT  = 8'h0C;
  localparam logic [7:0] OP_LE  = 8'h1C;
endpackage

// File: rtl/fpu_axis_hold.sv
// fpu_axis_hold: one channel's valid-hold and completion flag (clk, rst, start_i/need_i/ready_i in; valid_o, done_o out)
module fpu_axis_hold (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic need_i,
  input  logic ready_i,
  output logic valid_o,
  output logic done_o
);
  logic valid_q, done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      valid_q <= need_i;
      done_q  <= !need_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b1;
    end
  end
  assign valid_o = valid_q;
  assign done_o  = done_q || (valid_q && ready_i);
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue FSM (IDLE/SEND/RECV/DONE) routing one FP op to a unit over AXIS channels; FPU_TIMEOUT_EN adds a SEND/RECV watchdog
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int NUM_UNITS      = fpu_pkg::NUM_UNITS
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_unit,
  input  logic [7:0]                req_op,
  input  logic [31:0]               req_a,
  input  logic [31:0]               req_b,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [31:0]               u_a_tdata,
  output logic [31:0]               u_b_tdata,
  output logic [7:0]                u_op_tdata,
  output logic [NUM_UNITS-1:0]      u_a_tvalid,
  output logic [NUM_UNITS-1:0]      u_b_tvalid,
  output logic [NUM_UNITS-1:0]      u_op_tvalid,
  input  logic [NUM_UNITS-1:0]      u_a_tready,
  input  logic [NUM_UNITS-1:0]      u_b_tready,
  input  logic [NUM_UNITS-1:0]      u_op_tready,
  input  logic [NUM_UNITS-1:0]      u_r_tvalid,
  output logic [NUM_UNITS-1:0]      u_r_tready,
  input  logic [32*NUM_UNITS-1:0]   u_r_tdata
);
  import fpu_pkg::*;
  state_t state_q, state_d;
  logic [2:0] unit_q;
  logic [7:0] op_q;
  logic [31:0] a_q, b_q, rsp_data_q;
  logic rsp_err_q;
  logic [NUM_UNITS-1:0] sel;
  logic fire, legal, start, wait_st, r_hit, to_hit;
  logic a_v, b_v, op_v, a_d, b_d, op_d;
  assign fire    = req_valid && state_q == IDLE;
  assign legal   = 32'(req_unit) < NUM_UNITS;
  assign start   = fire && legal;
  assign wait_st = state_q == SEND || state_q == RECV;
  assign sel     = NUM_UNITS'(1) << unit_q;
  assign r_hit   = state_q == RECV && |(u_r_tvalid & sel);
  fpu_axis_hold u_hold_a (.clk(CLK), .rst(RST || to_hit), .start_i(start), .need_i(1'b1),
    .ready_i(|(u_a_tready & sel)), .valid_o(a_v), .done_o(a_d));
  fpu_axis_hold u_hold_b (.clk(CLK), .rst(RST || to_hit), .start_i(start), .need_i(req_unit <= U_COMP),
    .ready_i(|(u_b_tready & sel)), .valid_o(b_v), .done_o(b_d));
  fpu_axis_hold u_hold_op (.clk(CLK), .rst(RST || to_hit), .start_i(start),
    .need_i(req_unit == U_ADDSUB || req_unit == U_COMP),
    .ready_i(|(u_op_tready & sel)), .valid_o(op_v), .done_o(op_d));
`ifdef FPU_TIMEOUT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else cnt_q <= wait_st ? cnt_q + 32'd1 : '0;
  end
  assign to_hit = wait_st && cnt_q == 32'(TIMEOUT_CYCLES - 1);
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q == IDLE ? (req_valid ? (legal ? SEND : DONE) : IDLE) :
              state_q == SEND ? (to_hit ? DONE : (a_d && b_d && op_d) ? RECV : SEND) :
              state_q == RECV ? ((r_hit || to_hit) ? DONE : RECV) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      unit_q     <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        unit_q <= req_unit;
        op_q   <= req_op;
        a_q    <= req_a;
        b_q    <= req_b;
      end
      if (state_d == DONE && state_q != DONE) begin
        rsp_data_q <= r_hit ? u_r_tdata[32*unit_q +: 32] : '0;
        rsp_err_q  <= !r_hit;
      end
    end
  end
  assign req_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign rsp_valid   = state_q == DONE;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign u_a_tvalid  = a_v ? sel : '0;
  assign u_b_tvalid  = b_v ? sel : '0;
  assign u_op_tvalid = op_v ? sel : '0;
  assign u_a_tdata   = a_v ? a_q : '0;
  assign u_b_tdata   = b_v ? b_q : '0;
  assign u_op_tdata  = op_v ? op_q : '0;
  assign u_r_tready  = state_q == RECV ? sel : '0;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
  localparam int N = 7;
  logic CLK = 1'b0, RST = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_unit = '0;
  logic [7:0] req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_err, busy;
  logic [31:0] rsp_data, u_a_tdata, u_b_tdata;
  logic [7:0] u_op_tdata;
  logic [N-1:0] u_a_tvalid, u_b_tvalid, u_op_tvalid, u_r_tready;
  logic [N-1:0] u_a_tready = '0, u_b_tready = '0, u_op_tready = '0, u_r_tvalid = '0;
  logic [32*N-1:0] u_r_tdata = '0;
  int checks = 0, errors = 0;
  logic [32:0] exp_q[$];
  fpu_issue_ctrl #(.TIMEOUT_CYCLES(16), .NUM_UNITS(N)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .u_a_tdata(u_a_tdata), .u_b_tdata(u_b_tdata),
    .u_op_tdata(u_op_tdata), .u_a_tvalid(u_a_tvalid), .u_b_tvalid(u_b_tvalid),
    .u_op_tvalid(u_op_tvalid), .u_a_tready(u_a_tready), .u_b_tready(u_b_tready),
    .u_op_tready(u_op_tready), .u_r_tvalid(u_r_tvalid), .u_r_tready(u_r_tready),
    .u_r_tdata(u_r_tdata));
  always #5 CLK = ~CLK;
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic req(input logic [2:0] u, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_unit  = u;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask
  task automatic idle_outs(input string n);
    chk({n, "_req_ready"}, req_ready, 1);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_rsp"}, {rsp_valid, rsp_err, rsp_data}, 0);
    chk({n, "_tvalid_tready"}, {u_a_tvalid, u_b_tvalid, u_op_tvalid, u_r_tready}, 0);
    chk({n, "_tdata"}, {u_a_tdata, u_b_tdata, u_op_tdata}, 0);
  endtask
  always @(negedge CLK) begin
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %b expected no response", rsp_data, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({rsp_data, rsp_err} !== e) begin
          errors++;
          $display("FAIL rsp_scoreboard: got data %h err %b expected data %h err %b",
                   rsp_data, rsp_err, e[32:1], e[0]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    step(2);
    RST = 1'b0;
    idle_outs("reset");
    req(3'd7, 8'h00, 32'hDEAD, 32'hBEEF);
    exp_q.push_back({32'h0, 1'b1});
    step;
    req_valid = 1'b0;
    chk("illegal_rsp_c1", {rsp_valid, rsp_err, rsp_data}, {2'b11, 32'h0});
    chk("illegal_no_tvalid", {u_a_tvalid, u_b_tvalid, u_op_tvalid}, 0);
    step;
    chk("illegal_back_idle", req_ready, 1);
    u_a_tready = '1; u_b_tready = '1; u_op_tready = '1;
    req(3'd1, 8'h00, 32'h40000000, 32'h40400000);
    exp_q.push_back({32'h40C00000, 1'b0});
    step;
    req_valid = 1'b0;
    chk("mul_tvalid_c1", {u_a_tvalid, u_b_tvalid, u_op_tvalid}, {7'h02, 7'h02, 7'h00});
    chk("mul_tdata_c1", {u_a_tdata, u_b_tdata, u_op_tdata}, {32'h40000000, 32'h40400000, 8'h00});
    u_r_tdata[32 +: 32] = 32'h40C00000;
    step;
    u_r_tvalid = 7'h02;
    chk("mul_recv_c2", {u_a_tvalid, u_b_tvalid, u_r_tready}, {7'h00, 7'h00, 7'h02});
    step;
    u_r_tvalid = '0;
    chk("mul_rsp_valid_c3", rsp_valid, 1);
    step;
    chk("mul_after_done", {rsp_valid, req_ready, rsp_data}, {2'b01, 32'h40C00000});
    u_a_tready = '0; u_b_tready = '0; u_op_tready = '0;
    req(3'd3, 8'h0C, 32'h3F800000, 32'h40000000);
    exp_q.push_back({32'h1, 1'b0});
    step;
    req_valid = 1'b0;
    chk("lt_tvalid_c1", {u_a_tvalid, u_b_tvalid, u_op_tvalid}, {3{7'h08}});
    chk("lt_op_tdata", u_op_tdata, 8'h0C);
    u_a_tready = '1;
    step;
    u_a_tready = '0;
    chk("lt_tvalid_c2", {u_a_tvalid, u_b_tvalid, u_op_tvalid}, {7'h00, 7'h08, 7'h08});
    chk("lt_a_tdata_zero", u_a_tdata, 0);
    step;
    chk("lt_b_held_c3", {u_b_tvalid, u_b_tdata}, {7'h08, 32'h40000000});
    u_b_tready = '1;
    step;
    u_b_tready = '0;
    chk("lt_tvalid_c4", {u_a_tvalid, u_b_tvalid, u_op_tvalid}, {7'h00, 7'h00, 7'h08});
    step;
    chk("lt_no_recv_c5", {busy, u_r_tready}, {1'b1, 7'h00});
    u_op_tready = '1;
    step;
    u_op_tready = '0;
    chk("lt_recv_c6", {u_a_tvalid, u_b_tvalid, u_op_tvalid, u_r_tready}, {21'h0, 7'h08});
    u_r_tdata[96 +: 32] = 32'h1;
    u_r_tvalid = 7'h08;
    step;
    u_r_tvalid = '0;
    chk("lt_rsp_valid_c7", rsp_valid, 1);
    step;
    u_a_tready = '1; u_b_tready = '1; u_op_tready = '1;
    req(3'd2, 8'h00, 32'h3, 32'h4);
    step;
    req_valid = 1'b0;
    step;
    chk("div_recv_c2", u_r_tready, 7'h04);
    RST = 1'b1;
    step;
    RST = 1'b0;
    idle_outs("reset_in_recv");
    u_r_tdata[64 +: 32] = 32'h55;
    u_r_tvalid = 7'h04;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("stray_r_tvalid_ignored", {rsp_valid, busy}, 0);
    end
    u_r_tvalid = '0;
    req(3'd0, 8'h01, 32'h10, 32'h20);
    exp_q.push_back({32'h111, 1'b0});
    exp_q.push_back({32'h222, 1'b0});
    u_r_tdata[32 +: 32] = 32'hBAD;
    u_r_tvalid = 7'h02;
    step;
    chk("b2b_op1_send", {u_op_tvalid, u_op_tdata, u_a_tdata}, {7'h01, 8'h01, 32'h10});
    req_op = 8'h00; req_a = 32'h30; req_b = 32'h40;
    step;
    chk("b2b_op1_recv", u_r_tready, 7'h01);
    u_r_tdata[0 +: 32] = 32'h111;
    step;
    chk("b2b_unit1_ignored", {rsp_valid, u_r_tready}, {1'b0, 7'h01});
    u_r_tvalid = 7'h03;
    step;
    chk("b2b_op1_done", {rsp_valid, req_ready}, 2'b10);
    u_r_tvalid = 7'h02;
    step;
    chk("b2b_op2_accept_idle", req_ready, 1);
    step;
    req_valid = 1'b0;
    chk("b2b_op2_send", {busy, u_op_tvalid, u_op_tdata, u_a_tdata}, {1'b1, 7'h01, 8'h00, 32'h30});
    u_r_tdata[0 +: 32] = 32'h222;
    step;
    chk("b2b_op2_recv", u_r_tready, 7'h01);
    u_r_tvalid = 7'h03;
    step;
    u_r_tvalid = '0;
    chk("b2b_op2_done", rsp_valid, 1);
    step;
    req(3'd6, 8'h00, 32'h41800000, 32'h0);
`ifdef FPU_TIMEOUT_EN
    exp_q.push_back({32'h0, 1'b1});
`endif
    step;
    req_valid = 1'b0;
    chk("sqrt_tvalid_c1", {u_a_tvalid, u_b_tvalid, u_op_tvalid}, {7'h40, 7'h00, 7'h00});
    chk("sqrt_a_tdata", u_a_tdata, 32'h41800000);
`ifdef FPU_TIMEOUT_EN
    begin
      int c;
      c = 1;
      while (!rsp_valid && c < 40) begin
        step;
        c++;
      end
      chk("timeout_done_cycle", c, 17);
      step;
      chk("timeout_back_idle", {busy, u_r_tready}, 0);
    end
`else
    step(40);
    chk("no_timeout_busy", {busy, u_r_tready}, {1'b1, 7'h40});
    RST = 1'b1;
    step;
    RST = 1'b0;
`endif
    step(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
